reset_domain_sequencer: RTL
===========================

# reset_domain_sequencer

Sequences power-up and power-down of one reset domain in response to the four-phase `enable_req`/`enable_ack` handshake issued by the reset control node directly upstream. On request it ungates the domain clock, holds the domain in reset while the clock settles, releases reset, then drops isolation and acknowledges. On withdrawal it runs the mirror teardown: isolate, drain, reassert reset, gate the clock, then withdraw the acknowledge. It is the consumer of `enable_req` and the producer of `enable_ack`.

## Interface

- `SETTLE_CYCLES`, 4: cycles the clock runs with reset held, before reset release (1..2^CNT_W)
- `HOLD_CYCLES`, 2: cycles between reset edge and next step, used in both directions (1..2^CNT_W)
- `DRAIN_CYCLES`, 4: cycles isolation is held, before reset reassertion (1..2^CNT_W)
- `CNT_W`, 8: width of the shared down-counter
- `clock`  in  1  single clock for the block and its handshake partner
- `async_resetn`  in  1  reset, asynchronous assert, active-low
- `enable_req`  in  1  domain enable request from the upstream reset control node
- `enable_ack`  out  1  handshake acknowledge; 1 = domain up, or teardown not yet complete
- `domain_clock_enable`  out  1  enable for the domain clock gate
- `domain_resetn`  out  1  active-low reset into the domain
- `domain_isolate`  out  1  1 = domain outputs clamped
- `protocol_error`  out  1  one-cycle pulse on an illegal request change

## Operation

- Moore FSM with states OFF, CLK_ON, RST_REL, ON, DRAIN, RST_ASSERT, CLK_OFF. All outputs are flops loaded from the next-state decode, so they are glitch-free.
- Each state drives (clock_enable, resetn, isolate, ack):
  - OFF: 0,0,1,0
  - CLK_ON: 1,0,1,0
  - RST_REL: 1,1,1,0
  - ON: 1,1,0,1
  - DRAIN: 1,1,1,1
  - RST_ASSERT: 1,0,1,1
  - CLK_OFF: 0,0,1,1
- Transitions:
  - OFF → CLK_ON when `enable_req`=1.
  - CLK_ON → RST_REL after SETTLE_CYCLES.
  - RST_REL → ON after HOLD_CYCLES.
  - ON → DRAIN when `enable_req`=0.
  - DRAIN → RST_ASSERT after DRAIN_CYCLES.
  - RST_ASSERT → CLK_OFF after HOLD_CYCLES.
  - CLK_OFF → OFF after 1 cycle.
- Timed states share one CNT_W-bit down-counter. It is loaded with N-1 on state entry, and the state exits on the edge where the counter reads 0. N=1 gives one cycle in the state.
- `enable_req` is acted on only in OFF and ON. Transitional states always run to completion.
  - Request dropped during power-up: the block reaches ON, then begins teardown on the next edge.
  - Request raised during teardown: the block reaches OFF, then restarts power-up on the next edge.
- `protocol_error` pulses for one cycle, registered, when `enable_req` differs from its value on the previous edge while the state is CLK_ON, RST_REL, DRAIN, RST_ASSERT or CLK_OFF. The request is not otherwise acted on.
- `async_resetn` low, at any time including mid-sequence:
  - state = OFF, counter = 0, previous-request flop = 0
  - outputs immediately 0,0,1,0 and `protocol_error`=0
- Exit from reset is synchronous: the first edge with `async_resetn`=1 evaluates OFF normally.

## Timing

- Power-up: `enable_req` is first sampled high at edge E.
  - `domain_clock_enable` rises after E.
  - `domain_resetn` rises after E+SETTLE_CYCLES.
  - `domain_isolate` falls and `enable_ack` rises after E+SETTLE_CYCLES+HOLD_CYCLES.
  - Defaults: ack 6 cycles after E.
- Power-down: `enable_req` is first sampled low in ON at edge F.
  - `domain_isolate` rises after F.
  - `domain_resetn` falls after F+DRAIN_CYCLES.
  - `domain_clock_enable` falls after F+DRAIN_CYCLES+HOLD_CYCLES.
  - `enable_ack` falls after F+DRAIN_CYCLES+HOLD_CYCLES+1.
  - Defaults: ack falls 7 cycles after F.
- Invariants checked every cycle:
  - `domain_resetn`=1 implies `domain_clock_enable`=1.
  - `domain_isolate`=0 implies `domain_resetn`=1 and `enable_ack`=1.
  - `enable_ack` changes only on OFF→CLK_ON→…→ON entry and CLK_OFF→OFF.
- Counter never wraps: load values are at most 2^CNT_W-1 by parameter range.

## Test plan

- Defaults, req rises at E → clk_en=1 at E+1, resetn=1 at E+5, isolate=0 and ack=1 at E+7 (each value visible after its edge); no error pulse.
- From ON, req falls at F → isolate=1 at F+1, resetn=0 at F+5, clk_en=0 at F+7, ack=0 at F+8; back in OFF.
- Req pulses high 2 cycles from OFF → power-up completes, one `protocol_error` pulse when req falls, ON lasts 1 cycle, then full teardown to ack=0.
- Req rises 1 cycle into DRAIN → one error pulse, teardown completes to OFF, power-up restarts the next edge, ack returns after 6 more cycles.
- `async_resetn` asserted mid RST_REL → outputs 0,0,1,0 immediately; after release with req=1, full power-up repeats from OFF.
- All three cycle parameters = 1 → ack rises 2 cycles after request and falls 3 cycles after withdrawal; invariants hold throughout.

Source files
------------

// File: rtl/reset_domain_sequencer.sv
// Power sequencer for one reset domain. Brings the domain up (clock on, settle,
// release reset, de-isolate, ack) and tears it down in mirror order, driven by a
// four-phase enable_req/enable_ack handshake with the upstream reset control node.
module reset_domain_sequencer #(
    parameter int unsigned SETTLE_CYCLES = 4,
    parameter int unsigned HOLD_CYCLES   = 2,
    parameter int unsigned DRAIN_CYCLES  = 4,
    parameter int unsigned CNT_W         = 8
) (
    input  logic clock,
    input  logic async_resetn,
    input  logic enable_req,
    output logic enable_ack,
    output logic domain_clock_enable,
    output logic domain_resetn,
    output logic domain_isolate,
    output logic protocol_error
);

    typedef enum logic [2:0] {
        StOff,
        StClkOn,
        StRstRel,
        StOn,
        StDrain,
        StRstAssert,
        StClkOff
    } state_t;

    // Counter load values: a timed state of N cycles loads N-1 and exits when it reads 0
    localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LOAD   = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] DRAIN_LOAD  = CNT_W'(DRAIN_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

    state_t           r_state;
    state_t           w_state_next;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_next;
    logic             w_cnt_zero;
    logic             r_req_prev;
    logic             w_in_transit;
    logic             w_err_next;
    logic [3:0]       w_outs_next;
    logic             r_clk_en;
    logic             r_resetn;
    logic             r_isolate;
    logic             r_ack;
    logic             r_error;

    // Output pattern per state: {clock_enable, resetn, isolate, ack}
    function automatic logic [3:0] state_outputs(input state_t s);
        logic [3:0] o;
        unique case (s)
            StOff:       o = 4'b0010;
            StClkOn:     o = 4'b1010;
            StRstRel:    o = 4'b1110;
            StOn:        o = 4'b1101;
            StDrain:     o = 4'b1111;
            StRstAssert: o = 4'b1011;
            StClkOff:    o = 4'b0011;
            default:     o = 4'b0010;
        endcase
        return o;
    endfunction

    // Next-state, counter and error decode
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_cnt_zero   = (r_cnt == '0);
        unique case (r_state)
            StOff: begin
                if (enable_req) begin
                    w_state_next = StClkOn;
                    w_cnt_next   = SETTLE_LOAD;
                end
            end
            StClkOn: begin
                if (w_cnt_zero) begin
                    w_state_next = StRstRel;
                    w_cnt_next   = HOLD_LOAD;
                end else begin
                    w_cnt_next = r_cnt - CNT_ONE;
                end
            end
            StRstRel: begin
                if (w_cnt_zero) begin
                    w_state_next = StOn;
                end else begin
                    w_cnt_next = r_cnt - CNT_ONE;
                end
            end
            StOn: begin
                if (!enable_req) begin
                    w_state_next = StDrain;
                    w_cnt_next   = DRAIN_LOAD;
                end
            end
            StDrain: begin
                if (w_cnt_zero) begin
                    w_state_next = StRstAssert;
                    w_cnt_next   = HOLD_LOAD;
                end else begin
                    w_cnt_next = r_cnt - CNT_ONE;
                end
            end
            StRstAssert: begin
                if (w_cnt_zero) begin
                    w_state_next = StClkOff;
                end else begin
                    w_cnt_next = r_cnt - CNT_ONE;
                end
            end
            StClkOff: begin
                w_state_next = StOff;
            end
            default: begin
                w_state_next = StOff;
                w_cnt_next   = '0;
            end
        endcase

        // Request changes are illegal only while a sequence is in flight
        w_in_transit = (r_state != StOff) && (r_state != StOn);
        w_err_next   = w_in_transit && (enable_req != r_req_prev);
        w_outs_next  = state_outputs(w_state_next);
    end

    // State, counter and registered outputs loaded from the next-state decode
    always_ff @(posedge clock or negedge async_resetn) begin
        if (!async_resetn) begin
            r_state    <= StOff;
            r_cnt      <= '0;
            r_req_prev <= 1'b0;
            r_clk_en   <= 1'b0;
            r_resetn   <= 1'b0;
            r_isolate  <= 1'b1;
            r_ack      <= 1'b0;
            r_error    <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_cnt      <= w_cnt_next;
            r_req_prev <= enable_req;
            r_clk_en   <= w_outs_next[3];
            r_resetn   <= w_outs_next[2];
            r_isolate  <= w_outs_next[1];
            r_ack      <= w_outs_next[0];
            r_error    <= w_err_next;
        end
    end

    assign domain_clock_enable = r_clk_en;
    assign domain_resetn       = r_resetn;
    assign domain_isolate      = r_isolate;
    assign enable_ack          = r_ack;
    assign protocol_error      = r_error;

endmodule
